rv32_mem_arbiter: RTL

//  Shares one single-ported instruction/data memory between RV32I fetch (IF) and load/store (D).

---
 rtl/rv32_mem_pkg.sv | 25 ++
 rtl/rv32_mem_arb_pick.sv | 48 ++++
 rtl/rv32_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv32_mem_pkg
// Shared types and constants for the RV32I unified-memory arbiter.
//   state_t   : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   req_id_t  : requester identity (REQ_IF = fetch, REQ_D = load/store)
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
// ----------------------------------------------------------------------------
package rv32_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

endpackage : rv32_mem_pkg

// File: rtl/rv32_mem_arb_pick.sv
// ----------------------------------------------------------------------------
// rv32_mem_arb_pick
// Combinational winner select between the fetch and load/store requesters.
// Build option (macro MEM_ARB_RR_EN):
//   undefined : fixed priority, D wins a simultaneous request
//   defined   : round-robin on contention, the requester not granted last wins
// An uncontended request is granted to its requester in both builds.
// Ports:
//   if_req_i       fetch request
//   d_req_i        load/store request
//   last_winner_i  requester granted on the most recent IDLE->ISSUE
//   valid_o        at least one request present
//   winner_o       selected requester (meaningful only while valid_o)
// ----------------------------------------------------------------------------
module rv32_mem_arb_pick
  import rv32_mem_pkg::*;
(
  input  logic    if_req_i,
  input  logic    d_req_i,
  input  req_id_t last_winner_i,
  output logic    valid_o,
  output req_id_t winner_o
);

  assign valid_o = if_req_i | d_req_i;

  always_comb begin
    winner_o = REQ_D;
    if (if_req_i && !d_req_i) begin
      winner_o = REQ_IF;
    end else if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      // Alternate: whoever was not served last gets the memory now.
      winner_o = (last_winner_i == REQ_D) ? REQ_IF : REQ_D;
`else
      // A pending load/store already stalls the pipe, so it goes first.
      winner_o = REQ_D;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no history; keep the input visibly consumed.
  logic unused_last_winner;
  assign unused_last_winner = last_winner_i;
`endif

endmodule : rv32_mem_arb_pick

// File: rtl/rv32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv32_mem_arbiter
// Shares one single-ported memory between RV32I instruction fetch (IF) and
// load/store (D). One transaction is outstanding at a time:
//   IDLE  -> sample requests, latch winner and payload
//   ISSUE -> hold mem_req with a stable payload until mem_gnt
//   WAIT  -> wait for mem_rvalid; watchdog gives an error response after
//            TIMEOUT cycles (TIMEOUT = 0 disables the watchdog)
//   RESP  -> one-cycle response pulse to the winner
// All mem_* and response outputs come straight from flops.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration on contention
// (see rv32_mem_arb_pick); undefined gives fixed D-over-IF priority.
//
// Handshakes: a requester raises *_req with its payload and holds both until
// its *_rsp_valid pulse; it may change or drop them at the edge ending that
// pulse. Toward memory, mem_req and payload are held until the cycle mem_gnt
// is seen high; mem_rvalid is honoured only in WAIT, so any response that
// arrives outside WAIT (e.g. after a timeout) is discarded.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request side
//   if_rsp_valid/if_rsp_err/if_rdata fetch response side
//   d_req/d_we/d_addr/d_wdata/d_be load/store request side
//   d_rsp_valid/d_rsp_err/d_rdata  load/store response side (rdata 0 on stores)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  memory request
//   mem_gnt/mem_rvalid/mem_rdata   memory accept and response
//   busy                           FSM not in IDLE
//   dbg_state                      current FSM state, for checkers
// ----------------------------------------------------------------------------
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  // fetch side
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic                if_rsp_err,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store side
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_rsp_valid,
  output logic                d_rsp_err,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // status
  output logic                busy,
  output state_t              dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  // At least one bit so the disabled-watchdog build still elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t            state_q,       state_d;
  req_id_t           winner_q,      winner_d;
  req_id_t           last_winner_q, last_winner_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;

  logic              mem_req_q,     mem_req_d;
  logic              mem_we_q,      mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q,      mem_be_d;

  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              if_rsp_err_q,   if_rsp_err_d;
  logic [DATA_W-1:0] if_rdata_q,     if_rdata_d;
  logic              d_rsp_valid_q,  d_rsp_valid_d;
  logic              d_rsp_err_q,    d_rsp_err_d;
  logic [DATA_W-1:0] d_rdata_q,      d_rdata_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic    pick_valid;
  req_id_t pick_winner;

  rv32_mem_arb_pick u_pick (
    .if_req_i      (if_req),
    .d_req_i       (d_req),
    .last_winner_i (last_winner_q),
    .valid_o       (pick_valid),
    .winner_o      (pick_winner)
  );

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    winner_d       = winner_q;
    last_winner_d  = last_winner_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    if_rsp_valid_d = if_rsp_valid_q;
    if_rsp_err_d   = if_rsp_err_q;
    if_rdata_d     = if_rdata_q;
    d_rsp_valid_d  = d_rsp_valid_q;
    d_rsp_err_d    = d_rsp_err_q;
    d_rdata_d      = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = ISSUE;
          winner_d      = pick_winner;
          last_winner_d = pick_winner;
          mem_req_d     = 1'b1;
          if (pick_winner == REQ_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            // Fetch is always a full-word read.
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end

      ISSUE: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
          if (winner_q == REQ_D) begin
            d_rsp_valid_d = 1'b1;
            d_rsp_err_d   = 1'b0;
            // Stores carry no read data back to the pipeline.
            d_rdata_d     = mem_we_q ? '0 : mem_rdata;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_err_d   = 1'b0;
            if_rdata_d     = mem_rdata;
          end
        end else begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
          // The current cycle is the TIMEOUT-th one spent in WAIT.
          if (WDOG_EN && (cnt_q == CNT_LAST)) begin
            state_d = RESP;
            if (winner_q == REQ_D) begin
              d_rsp_valid_d = 1'b1;
              d_rsp_err_d   = 1'b1;
              d_rdata_d     = '0;
            end else begin
              if_rsp_valid_d = 1'b1;
              if_rsp_err_d   = 1'b1;
              if_rdata_d     = '0;
            end
          end
        end
      end

      RESP: begin
        state_d        = IDLE;
        if_rsp_valid_d = 1'b0;
        if_rsp_err_d   = 1'b0;
        d_rsp_valid_d  = 1'b0;
        d_rsp_err_d    = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      winner_q       <= REQ_IF;
      last_winner_q  <= REQ_D;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rdata_q     <= '0;
      d_rsp_valid_q  <= 1'b0;
      d_rsp_err_q    <= 1'b0;
      d_rdata_q      <= '0;
    end else begin
      state_q        <= state_d;
      winner_q       <= winner_d;
      last_winner_q  <= last_winner_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_err_q   <= if_rsp_err_d;
      if_rdata_q     <= if_rdata_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      d_rsp_err_q    <= d_rsp_err_d;
      d_rdata_q      <= d_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign if_rdata     = if_rdata_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_err    = d_rsp_err_q;
  assign d_rdata      = d_rdata_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

endmodule : rv32_mem_arbiter
